clock_reset_sequencer: RTL

Parametrised PLL supervisor and reset sequencer for N clock domains, running on the free-running board reference clock. Drives the PLL reset, qualifies the lock signal (sync + stability window + timeout retry) and releases per-domain resets in ascending order with a fixed gap. Detects lock loss, re-asserts all domain resets, counts the events and restarts the PLL. Sits beside the PLL wrapper at the top level; its domain resets feed the per-domain reset synchronisers of the MAC/PCS blocks.

---
 rtl/clock_reset_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/clock_reset_sequencer.sv
// PLL supervisor and reset sequencer.
// Pulses the PLL reset, then qualifies the lock input: it is synchronised,
// required to be stable for a window, and retried after a timeout. Domain
// resets are then released one at a time in ascending order. Losing lock
// after release re-asserts every domain reset, counts the event and
// restarts the PLL.
module clock_reset_sequencer #(
    parameter int N_DOMAINS           = 2,
    parameter int PLL_RST_CYCLES      = 8,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int RELEASE_GAP_CYCLES  = 16,
    parameter int CNT_W               = 17
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_pll_locked,
    output logic                 o_pll_reset,
    output logic [N_DOMAINS-1:0] o_domain_reset,
    output logic                 o_all_ready,
    output logic [7:0]           o_lock_lost_count,
    output logic [2:0]           o_state
);

    localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
    localparam logic [N_DOMAINS-1:0] DOM_ALL = {N_DOMAINS{1'b1}};
    localparam logic [N_DOMAINS-1:0] DOM_ONE = N_DOMAINS'(1);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;     // next domain index to release
    logic [N_DOMAINS-1:0] dom_q, dom_d;
    logic                 ready_q, ready_d;
    logic [7:0]           lost_q, lost_d;
    logic                 pll_rst_q;
    logic                 sync1_q, locked_s;

    // Two-flop synchroniser for the asynchronous lock input.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1_q  <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1_q  <= i_pll_locked;
            locked_s <= sync1_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            idx_q     <= '0;
            dom_q     <= DOM_ALL;
            ready_q   <= 1'b0;
            lost_q    <= 8'd0;
            pll_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            dom_q     <= dom_d;
            ready_q   <= ready_d;
            lost_q    <= lost_d;
            pll_rst_q <= (state_d == PLL_RST);
        end
    end

    // Next-state logic; lock loss in RELEASE/RUN takes priority over release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        ready_d = ready_q;
        lost_d  = lost_q;
        case (state_q)
            PLL_RST: begin
                if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    // A glitch before release only restarts qualification.
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                    cnt_d    = '0;
                    dom_d[0] = 1'b0;
                    idx_d    = IDX_W'(1);
                    if (N_DOMAINS == 1) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE, RUN: begin
                if (!locked_s) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                    idx_d   = '0;
                    dom_d   = DOM_ALL;
                    ready_d = 1'b0;
                    if (lost_q != 8'hFF) begin
                        lost_d = lost_q + 8'd1;
                    end
                end else if (state_q == RELEASE) begin
                    if (cnt_q == CNT_W'(RELEASE_GAP_CYCLES - 1)) begin
                        cnt_d = '0;
                        dom_d = dom_q & ~(DOM_ONE << idx_q);
                        idx_d = idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(N_DOMAINS - 1)) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
                idx_d   = '0;
                dom_d   = DOM_ALL;
                ready_d = 1'b0;
            end
        endcase
    end

    assign o_pll_reset       = pll_rst_q;
    assign o_domain_reset    = dom_q;
    assign o_all_ready       = ready_q;
    assign o_lock_lost_count = lost_q;
    assign o_state           = state_q;

endmodule
